// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator for the HDMI path.
// Horizontal/vertical timing and sync polarities are set per axis by parameters.
// All outputs are registered from the next-state position so they stay aligned.
// Optional macro VTG_LEAD_EN adds lead_x/lead_y/lead_de, running LEAD ce-periods
// ahead of drawX/drawY for pixel-fetch pipelines.
module video_timing_gen #(
    parameter int CW       = 11,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int FCW      = 8
`ifdef VTG_LEAD_EN
    ,
    parameter int LEAD     = 2
`endif
) (
    input  logic           pixel_clk,
    input  logic           reset,
    input  logic           ce,
    input  logic [CW-1:0]  line_cmp,
    output logic           hs,
    output logic           vs,
    output logic           de,
    output logic           hblank,
    output logic           vblank,
    output logic [CW-1:0]  drawX,
    output logic [CW-1:0]  drawY,
    output logic           sol,
    output logic           sof,
    output logic           line_irq,
    output logic [FCW-1:0] frame_cnt
`ifdef VTG_LEAD_EN
    ,
    output logic [CW-1:0]  lead_x,
    output logic [CW-1:0]  lead_y,
    output logic           lead_de
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] HT_M1    = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] VT_M1    = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ON    = (HS_POL != 0);
    localparam logic          VS_ON    = (VS_POL != 0);

    // Totals must fit the coordinate counters (equality would alias 0).
    generate
        if (H_TOTAL >= (1 << CW) || V_TOTAL >= (1 << CW)) begin : g_bad_cw
            $error("video_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
        end
    endgenerate

    logic [CW-1:0] r_x, r_y;
    logic [CW-1:0] w_nx, w_ny;
    logic          w_x_wrap;
    logic          w_sol_n;
    logic          w_sof_n;

    // Next raster position: x wraps at end of line and carries into y.
    always_comb begin
        w_x_wrap = (r_x == HT_M1);
        w_nx     = w_x_wrap ? '0 : r_x + CW'(1);
        w_ny     = r_y;
        if (w_x_wrap)
            w_ny = (r_y == VT_M1) ? '0 : r_y + CW'(1);
        w_sol_n  = (w_nx == '0);
        w_sof_n  = w_sol_n && (w_ny == '0);
    end

    // Position counters; reset to the last pixel so the first ce edge lands on (0,0).
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_x <= HT_M1;
            r_y <= VT_M1;
        end else if (ce) begin
            r_x <= w_nx;
            r_y <= w_ny;
        end
    end

    // Registered outputs, all decoded from the same next-state position.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            hs        <= ~HS_ON;
            vs        <= ~VS_ON;
            de        <= 1'b0;
            hblank    <= 1'b1;
            vblank    <= 1'b1;
            drawX     <= '0;
            drawY     <= '0;
            sol       <= 1'b0;
            sof       <= 1'b0;
            line_irq  <= 1'b0;
            frame_cnt <= '1;
        end else if (ce) begin
            hs        <= (w_nx >= HS_START && w_nx < HS_END) ? HS_ON : ~HS_ON;
            // y only moves when x wraps, so vs is line-aligned by construction
            vs        <= (w_ny >= VS_START && w_ny < VS_END) ? VS_ON : ~VS_ON;
            de        <= (w_nx < H_ACT) && (w_ny < V_ACT);
            hblank    <= (w_nx >= H_ACT);
            vblank    <= (w_ny >= V_ACT);
            drawX     <= w_nx;
            drawY     <= w_ny;
            sol       <= w_sol_n;
            sof       <= w_sof_n;
            // w_ny never reaches V_TOTAL, so an out-of-range line_cmp never fires
            line_irq  <= w_sol_n && (w_ny == line_cmp);
            if (w_sof_n)
                frame_cnt <= frame_cnt + FCW'(1);
        end
    end

`ifdef VTG_LEAD_EN
    generate
        if (LEAD < 1 || LEAD >= H_TOTAL) begin : g_bad_lead
            $error("video_timing_gen: LEAD must satisfy 1 <= LEAD < H_TOTAL");
        end
    endgenerate

    logic [CW-1:0] r_lx, r_ly;
    logic [CW-1:0] w_nlx, w_nly;
    logic          w_lx_wrap;

    // Lead position follows the same wrap rules; its reset state is the
    // main reset position advanced by LEAD pixels.
    always_comb begin
        w_lx_wrap = (r_lx == HT_M1);
        w_nlx     = w_lx_wrap ? '0 : r_lx + CW'(1);
        w_nly     = r_ly;
        if (w_lx_wrap)
            w_nly = (r_ly == VT_M1) ? '0 : r_ly + CW'(1);
    end

    // Lead counters and registered lead data-enable.
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            r_lx    <= CW'(LEAD - 1);
            r_ly    <= '0;
            lead_de <= 1'b0;
        end else if (ce) begin
            r_lx    <= w_nlx;
            r_ly    <= w_nly;
            lead_de <= (w_nlx < H_ACT) && (w_nly < V_ACT);
        end
    end

    assign lead_x = r_lx;
    assign lead_y = r_ly;
`endif

endmodule
